// File: rtl/uart_frame_checker_pkg.sv
// Shared types and helpers for the UART frame checker.
//   state_t        : receiver FSM states
//   PAR_EVEN/ODD   : encodings of the PAR_TYP input
//   SAMPLE_OFFSET  : distance of the outer majority samples from mid-bit
//   sat_inc        : increment that sticks at all-ones for a given width
package uart_frame_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned SAMPLE_OFFSET = 1;

  // Operates on a 64-bit carrier; callers zero-extend and truncate back.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = {64{1'b1}} >> (64 - width);
    return (value == max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/exp_fifo.sv
// Expected-data FIFO for the frame checker.
//   clk, rst   : clock, asynchronous active-high reset
//   push_data  : entry to write; push writes when not full
//   pop        : drop the head entry when not empty
//   full/empty : status, decided by the extra pointer MSB
//   head       : current oldest entry
module exp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_frame_checker.sv
// Oversampling UART receiver that checks each frame against an expected-data
// queue and reports per-frame results plus saturating pass/fail counters.
//   CLK, RST            : oversampling clock, asynchronous active-high reset
//   SER_IN              : serial line (idle high)
//   PRESCALE, PAR_EN,
//   PAR_TYP, STOP2      : frame format, latched at start-bit detection
//   EXP_DATA/VALID/READY: expected-payload push handshake
//   CLR_CNT             : synchronous clear of PASS_CNT/FAIL_CNT
//   FRAME_DONE, MATCH, MISMATCH, NO_EXP, PAR_ERR, STP_ERR : one-cycle pulses
//   FRAME_DATA          : last received payload
//   PASS_CNT, FAIL_CNT  : saturating result counters
module uart_frame_checker
  import uart_frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int Prescale_width = 6,
  parameter int DEPTH          = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SER_IN,
  input  logic [Prescale_width-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [DATA_WIDTH-1:0]     EXP_DATA,
  input  logic                      EXP_VALID,
  output logic                      EXP_READY,
  input  logic                      CLR_CNT,
  output logic                      FRAME_DONE,
  output logic [DATA_WIDTH-1:0]     FRAME_DATA,
  output logic                      MATCH,
  output logic                      MISMATCH,
  output logic                      NO_EXP,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic [COUNT_WIDTH-1:0]    PASS_CNT,
  output logic [COUNT_WIDTH-1:0]    FAIL_CNT
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]          BIT_ONE  = BIT_W'(1);
  localparam logic [Prescale_width-1:0] ONE      = Prescale_width'(1);
  localparam logic [Prescale_width-1:0] OFFSET   = Prescale_width'(SAMPLE_OFFSET);

  state_t                    state;
  logic [Prescale_width-1:0] edge_cnt;
  logic [Prescale_width-1:0] prescale_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      stop2_q;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      second_stop;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_err_q;
  logic                      stp_err_q;
  logic                      had_exp;
  logic [2:0]                samples;

  logic [Prescale_width-1:0] mid;
  logic                      last_edge;
  logic                      bit_val;
  logic                      stp_final;
  logic                      frame_ok;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [DATA_WIDTH-1:0]     fifo_head;

  assign mid       = prescale_q >> 1;
  assign last_edge = (edge_cnt == prescale_q - ONE);
  assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  assign stp_final = stp_err_q | ~bit_val;
  assign frame_ok  = !par_err_q && !stp_final && (shift_reg == fifo_head);

  assign EXP_READY = ~fifo_full;
  // had_exp captures emptiness at the result decision, so the pop stays
  // consistent with the reported result even if a push lands meanwhile.
  assign fifo_pop  = (state == CHECK) && had_exp;

  exp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_exp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push_data (EXP_DATA),
    .push      (EXP_VALID && !fifo_full),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samples <= '0;
    end else if (state != IDLE && state != CHECK) begin
      if (edge_cnt == mid - OFFSET) samples[0] <= SER_IN;
      if (edge_cnt == mid)          samples[1] <= SER_IN;
      if (edge_cnt == mid + OFFSET) samples[2] <= SER_IN;
    end
  end

  // Result pulses are registered at the final stop-bit decision so they are
  // high exactly during the CHECK cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      prescale_q  <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      bit_cnt     <= '0;
      second_stop <= 1'b0;
      shift_reg   <= '0;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      had_exp     <= 1'b0;
      FRAME_DONE  <= 1'b0;
      FRAME_DATA  <= '0;
      MATCH       <= 1'b0;
      MISMATCH    <= 1'b0;
      NO_EXP      <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      MATCH      <= 1'b0;
      MISMATCH   <= 1'b0;
      NO_EXP     <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (state != IDLE && state != CHECK)
        edge_cnt <= last_edge ? '0 : edge_cnt + ONE;
      case (state)
        IDLE: begin
          if (!SER_IN) begin
            state       <= START;
            edge_cnt    <= ONE;
            prescale_q  <= PRESCALE;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
            stop2_q     <= STOP2;
            bit_cnt     <= '0;
            second_stop <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
          end
        end
        START: begin
          if (last_edge) state <= bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (last_edge) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BIT_ONE;
            if (bit_cnt == LAST_BIT) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_err_q <= (((^shift_reg) ^ bit_val) ? PAR_ODD : PAR_EVEN) != par_typ_q;
            state     <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            if (stop2_q && !second_stop) begin
              second_stop <= 1'b1;
              stp_err_q   <= stp_final;
            end else begin
              state      <= CHECK;
              had_exp    <= !fifo_empty;
              FRAME_DONE <= 1'b1;
              FRAME_DATA <= shift_reg;
              PAR_ERR    <= par_err_q;
              STP_ERR    <= stp_final;
              NO_EXP     <= fifo_empty;
              MATCH      <= !fifo_empty && frame_ok;
              MISMATCH   <= !fifo_empty && !frame_ok;
            end
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
    end else if (CLR_CNT) begin
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
    end else if (state == CHECK) begin
      if (MATCH)
        PASS_CNT <= COUNT_WIDTH'(sat_inc(64'(PASS_CNT), COUNT_WIDTH));
      if (MISMATCH || NO_EXP)
        FAIL_CNT <= COUNT_WIDTH'(sat_inc(64'(FAIL_CNT), COUNT_WIDTH));
    end
  end

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench for uart_frame_checker: a default instance plus a second
// instance with 2-bit counters sharing the same stimulus.
module tb_uart_frame_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SER_IN;
  logic [5:0]  PRESCALE;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [7:0]  EXP_DATA;
  logic        EXP_VALID;
  logic        CLR_CNT;

  logic        exp_ready, frame_done, match, mismatch, no_exp, par_err, stp_err;
  logic [7:0]  frame_data;
  logic [15:0] pass_cnt, fail_cnt;

  logic        s_exp_ready, s_frame_done, s_match, s_mismatch, s_no_exp, s_par_err, s_stp_err;
  logic [7:0]  s_frame_data;
  logic [1:0]  s_pass_cnt, s_fail_cnt;

  int checks = 0;
  int failures = 0;

  // {MATCH, MISMATCH, NO_EXP, PAR_ERR, STP_ERR}
  localparam logic [4:0] R_MATCH = 5'b10000;
  localparam logic [4:0] R_MISM  = 5'b01000;
  localparam logic [4:0] R_NOEXP = 5'b00100;
  localparam logic [4:0] R_PAR   = 5'b01010;
  localparam logic [4:0] R_STP   = 5'b01001;

  always #5 CLK = ~CLK;

  uart_frame_checker #(
    .DATA_WIDTH(8), .Prescale_width(6), .DEPTH(4), .COUNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .EXP_DATA(EXP_DATA), .EXP_VALID(EXP_VALID),
    .EXP_READY(exp_ready), .CLR_CNT(CLR_CNT), .FRAME_DONE(frame_done),
    .FRAME_DATA(frame_data), .MATCH(match), .MISMATCH(mismatch), .NO_EXP(no_exp),
    .PAR_ERR(par_err), .STP_ERR(stp_err), .PASS_CNT(pass_cnt), .FAIL_CNT(fail_cnt)
  );

  uart_frame_checker #(
    .DATA_WIDTH(8), .Prescale_width(6), .DEPTH(4), .COUNT_WIDTH(2)
  ) dut_sat (
    .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .EXP_DATA(EXP_DATA), .EXP_VALID(EXP_VALID),
    .EXP_READY(s_exp_ready), .CLR_CNT(CLR_CNT), .FRAME_DONE(s_frame_done),
    .FRAME_DATA(s_frame_data), .MATCH(s_match), .MISMATCH(s_mismatch), .NO_EXP(s_no_exp),
    .PAR_ERR(s_par_err), .STP_ERR(s_stp_err), .PASS_CNT(s_pass_cnt), .FAIL_CNT(s_fail_cnt)
  );

  task automatic drive_bit(input logic b);
    SER_IN = b;
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s1);
    if (STOP2) drive_bit(s2);
    SER_IN = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    EXP_DATA  = v;
    EXP_VALID = 1'b1;
    @(posedge CLK);
    #1;
    EXP_VALID = 1'b0;
  endtask

  task automatic wait_frame(output logic got, output logic [7:0] data, output logic [4:0] res);
    got = 1'b0;
    data = '0;
    res = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (frame_done) begin
        got  = 1'b1;
        data = frame_data;
        res  = {match, mismatch, no_exp, par_err, stp_err};
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({frame_done, match, mismatch, no_exp, par_err, stp_err, frame_data} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {frame_done, match, mismatch, no_exp, par_err, stp_err, frame_data});
    end
    checks++;
    if (exp_ready !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_ready_cnt got=%b/%0d/%0d exp=1/0/0", exp_ready, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_match();
    logic got; logic [7:0] d; logic [4:0] r;
    push(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_MATCH || d !== 8'hA5) begin
      failures++;
      $display("FAIL match_a5 got=%b res=%b data=%h exp res=%b data=a5", got, r, d, R_MATCH);
    end
    checks++;
    if (frame_done !== 1'b0 || pass_cnt !== 16'd1 || s_pass_cnt !== 2'd1) begin
      failures++;
      $display("FAIL match_cnt got done=%b pass=%0d spass=%0d exp 0/1/1", frame_done, pass_cnt, s_pass_cnt);
    end
  endtask

  task automatic test_errors();
    logic got; logic [7:0] d; logic [4:0] r;
    push(8'h0E);
    send_frame(8'h21, 1'b0, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_MISM || d !== 8'h21 || fail_cnt !== 16'd1) begin
      failures++;
      $display("FAIL data_err got=%b res=%b data=%h fail=%0d exp res=%b data=21 fail=1", got, r, d, fail_cnt, R_MISM);
    end
    push(8'h21);
    send_frame(8'h21, 1'b1, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_PAR || fail_cnt !== 16'd2) begin
      failures++;
      $display("FAIL par_err got=%b res=%b fail=%0d exp res=%b fail=2", got, r, fail_cnt, R_PAR);
    end
  endtask

  task automatic test_stop();
    logic got; logic [7:0] d; logic [4:0] r;
    STOP2 = 1'b1;
    push(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_STP || fail_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stop_err got=%b res=%b fail=%0d exp res=%b fail=3", got, r, fail_cnt, R_STP);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_NOEXP || d !== 8'h3C || fail_cnt !== 16'd4) begin
      failures++;
      $display("FAIL no_exp got=%b res=%b data=%h fail=%0d exp res=%b data=3c fail=4", got, r, d, fail_cnt, R_NOEXP);
    end
    checks++;
    if (s_fail_cnt !== 2'd3 || frame_data !== 8'h3C) begin
      failures++;
      $display("FAIL fail_sat got=%0d data=%h exp 3 data=3c", s_fail_cnt, frame_data);
    end
    STOP2 = 1'b0;
  endtask

  task automatic test_glitch();
    int seen = 0;
    repeat (3) @(posedge CLK);
    #1;
    SER_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    SER_IN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (frame_done) seen++;
    end
    @(posedge CLK);
    #1;
    checks++;
    if (seen != 0 || pass_cnt !== 16'd1 || fail_cnt !== 16'd4) begin
      failures++;
      $display("FAIL glitch got done=%0d pass=%0d fail=%0d exp 0/1/4", seen, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic got; logic [7:0] d; logic [4:0] r;
    push(8'h77);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({frame_done, match, mismatch, no_exp, par_err, stp_err, frame_data} !== 14'h0 ||
        exp_ready !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got out=%h ready=%b pass=%0d fail=%0d exp 0/1/0/0",
               {frame_done, match, mismatch, no_exp, par_err, stp_err, frame_data},
               exp_ready, pass_cnt, fail_cnt);
    end
    SER_IN = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    push(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_MATCH || d !== 8'h5A || pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
      failures++;
      $display("FAIL after_reset got=%b res=%b data=%h pass=%0d fail=%0d exp res=%b data=5a 1/0",
               got, r, d, pass_cnt, fail_cnt, R_MATCH);
    end
  endtask

  task automatic test_fifo_bounds();
    logic got; logic [7:0] d; logic [4:0] r;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) push(vals[i]);
    checks++;
    if (exp_ready !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full got ready=%b exp=0", exp_ready);
    end
    push(8'h55);
    for (int i = 0; i < 4; i++) begin
      send_frame(vals[i], ^vals[i], 1'b1, 1'b1);
      wait_frame(got, d, r);
      checks++;
      if (!got || r !== R_MATCH || d !== vals[i]) begin
        failures++;
        $display("FAIL fifo_order[%0d] got=%b res=%b data=%h exp res=%b data=%h", i, got, r, d, R_MATCH, vals[i]);
      end
    end
    checks++;
    if (pass_cnt !== 16'd4 || exp_ready !== 1'b1) begin
      failures++;
      $display("FAIL fifo_pass got pass=%0d ready=%b exp 4/1", pass_cnt, exp_ready);
    end
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    wait_frame(got, d, r);
    checks++;
    if (!got || r !== R_NOEXP) begin
      failures++;
      $display("FAIL fifo_5th_refused got=%b res=%b exp res=%b", got, r, R_NOEXP);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb_data [2];
    logic [4:0] bb_res [2];
    int n = 0;
    push(8'h81);
    push(8'h7E);
    fork
      begin
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 300 && n < 2; i++) begin
          @(negedge CLK);
          if (frame_done) begin
            bb_data[n] = frame_data;
            bb_res[n]  = {match, mismatch, no_exp, par_err, stp_err};
            n++;
          end
        end
      end
    join
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=2", n);
    end else begin
      checks++;
      if (bb_res[0] !== R_MATCH || bb_data[0] !== 8'h81 || bb_res[1] !== R_MATCH || bb_data[1] !== 8'h7E) begin
        failures++;
        $display("FAIL b2b_frames got %b/%h %b/%h exp %b/81 %b/7e",
                 bb_res[0], bb_data[0], bb_res[1], bb_data[1], R_MATCH, R_MATCH);
      end
    end
    checks++;
    if (pass_cnt !== 16'd6) begin
      failures++;
      $display("FAIL b2b_pass got=%0d exp=6", pass_cnt);
    end
  endtask

  task automatic test_saturation();
    logic got; logic [7:0] d; logic [4:0] r;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = 8'h30 + 8'(i);
      push(v);
      send_frame(v, ^v, 1'b1, 1'b1);
      wait_frame(got, d, r);
    end
    checks++;
    if (s_pass_cnt !== 2'd3 || pass_cnt !== 16'd5) begin
      failures++;
      $display("FAIL pass_sat got spass=%0d pass=%0d exp 3/5", s_pass_cnt, pass_cnt);
    end
    push(8'h99);
    send_frame(8'h99, 1'b0, 1'b1, 1'b1);
    CLR_CNT = 1'b1;
    wait_frame(got, d, r);
    CLR_CNT = 1'b0;
    checks++;
    if (!got || r !== R_MATCH) begin
      failures++;
      $display("FAIL clr_frame got=%b res=%b exp res=%b", got, r, R_MATCH);
    end
    checks++;
    if (pass_cnt !== 16'd0 || s_pass_cnt !== 2'd0 || fail_cnt !== 16'd0) begin
      failures++;
      $display("FAIL clr_wins got pass=%0d spass=%0d fail=%0d exp 0/0/0", pass_cnt, s_pass_cnt, fail_cnt);
    end
  endtask

  initial begin
    RST       = 1'b1;
    SER_IN    = 1'b1;
    PRESCALE  = 6'd8;
    PAR_EN    = 1'b1;
    PAR_TYP   = 1'b0;
    STOP2     = 1'b0;
    EXP_DATA  = '0;
    EXP_VALID = 1'b0;
    CLR_CNT   = 1'b0;
    test_reset();
    test_match();
    test_errors();
    test_stop();
    test_glitch();
    test_reset_mid();
    test_fifo_bounds();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
